// File: rtl/serial_tx_unit.sv
// Serial transmit engine: input FIFO, latched divisor, MSB/LSB-first
// shifter driving D_OUT / D_OUT_VALID / CLK_Tx.
module serial_tx_unit #(
  parameter int DATA_W     = 32,
  parameter int DIV_W      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 1
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          CONFIG_DIV,
  input  logic [DIV_W-1:0]              DIN,
  input  logic                          WR_EN,
  input  logic [DATA_W-1:0]             DATA,
  output logic                          FULL,
  output logic                          EMPTY,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
  output logic                          BUSY,
  output logic                          OVF,
  output logic                          D_OUT,
  output logic                          D_OUT_VALID,
  output logic                          CLK_Tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(DATA_W + 1);

  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BITS_L  = BW'(DATA_W);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]        r_state;
  logic [DIV_W-1:0]  r_div;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [LW-1:0]     r_level;
  logic              r_ovf;
  logic [DATA_W-1:0] r_sh;
  logic [BW-1:0]     r_bits;
  logic [DIV_W-1:0]  r_n;
  logic [DIV_W-1:0]  r_cnt;
  logic              r_ph;

  logic              w_full;
  logic              w_empty;
  logic              w_shift;
  logic              w_wr;
  logic              w_pop;
  logic              w_half_end;
  logic              w_bit_end;
  logic              w_last;
  logic [DIV_W-1:0]  w_n_eff;
  logic [DATA_W-1:0] w_sh_next;

  assign w_full  = (r_level == DEPTH_L);
  assign w_empty = (r_level == '0);
  assign w_shift = (r_state == ST_SHIFT);
  assign w_wr    = WR_EN && !w_full;

  // r_ph selects the low (0) or high (1) half of a bit
  assign w_half_end = w_shift && (r_cnt == r_n - DIV_W'(1));
  assign w_bit_end  = w_half_end && r_ph;
  assign w_last     = w_bit_end && (r_bits == BW'(1));
  assign w_pop      = !w_empty && (!w_shift || w_last);

  assign w_n_eff = (r_div == '0) ? DIV_W'(1) : r_div;

  assign w_sh_next = (MSB_FIRST != 0)
                   ? {r_sh[DATA_W-2:0], 1'b0}
                   : {1'b0, r_sh[DATA_W-1:1]};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_div <= DIV_W'(1);
    end else if (CONFIG_DIV) begin
      r_div <= DIN;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr) begin
      r_mem[r_wptr] <= DATA;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (WR_EN && w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_sh    <= '0;
      r_bits  <= '0;
      r_n     <= DIV_W'(1);
      r_cnt   <= '0;
      r_ph    <= 1'b0;
    end else if (w_pop) begin
      r_state <= ST_SHIFT;
      r_sh    <= r_mem[r_rptr];
      r_bits  <= BITS_L;
      r_n     <= w_n_eff;
      r_cnt   <= '0;
      r_ph    <= 1'b0;
    end else if (w_shift) begin
      if (w_last) begin
        r_state <= ST_IDLE;
        r_sh    <= '0;
        r_bits  <= '0;
        r_cnt   <= '0;
        r_ph    <= 1'b0;
      end else if (w_bit_end) begin
        r_sh    <= w_sh_next;
        r_bits  <= r_bits - BW'(1);
        r_cnt   <= '0;
        r_ph    <= 1'b0;
      end else if (w_half_end) begin
        r_cnt   <= '0;
        r_ph    <= 1'b1;
      end else begin
        r_cnt   <= r_cnt + DIV_W'(1);
      end
    end
  end

  assign FULL        = w_full;
  assign EMPTY       = w_empty;
  assign LEVEL       = r_level;
  assign OVF         = r_ovf;
  assign BUSY        = w_shift || !w_empty;
  assign D_OUT_VALID = w_shift;
  assign CLK_Tx      = w_shift && r_ph;
  assign D_OUT       = w_shift &&
                       ((MSB_FIRST != 0) ? r_sh[DATA_W-1] : r_sh[0]);

endmodule

// File: tb/tb_serial_tx_unit.sv
// Directed bench for serial_tx_unit: one MSB-first and one LSB-first
// instance share stimulus; each scenario task checks its own results.
module tb_serial_tx_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CONFIG_DIV = 1'b0;
  logic [31:0] DIN = '0;
  logic        WR_EN = 1'b0;
  logic [31:0] DATA = '0;

  logic       m_full, m_empty, m_busy, m_ovf, m_dout, m_vld, m_clk;
  logic [2:0] m_level;
  logic       l_full, l_empty, l_busy, l_ovf, l_dout, l_vld, l_clk;
  logic [2:0] l_level;

  int n_checks = 0;
  int n_fail   = 0;

  logic m_d [0:1023];
  logic m_c [0:1023];
  logic l_d [0:1023];
  logic l_c [0:1023];
  int   m_len, l_len, m_first, l_first;

  always #5 CLK = ~CLK;

  serial_tx_unit #(
    .DATA_W(32), .DIV_W(32), .FIFO_DEPTH(4), .MSB_FIRST(1)
  ) u_msb (
    .CLK(CLK), .RESET(RESET), .CONFIG_DIV(CONFIG_DIV), .DIN(DIN),
    .WR_EN(WR_EN), .DATA(DATA), .FULL(m_full), .EMPTY(m_empty),
    .LEVEL(m_level), .BUSY(m_busy), .OVF(m_ovf), .D_OUT(m_dout),
    .D_OUT_VALID(m_vld), .CLK_Tx(m_clk)
  );

  serial_tx_unit #(
    .DATA_W(32), .DIV_W(32), .FIFO_DEPTH(4), .MSB_FIRST(0)
  ) u_lsb (
    .CLK(CLK), .RESET(RESET), .CONFIG_DIV(CONFIG_DIV), .DIN(DIN),
    .WR_EN(WR_EN), .DATA(DATA), .FULL(l_full), .EMPTY(l_empty),
    .LEVEL(l_level), .BUSY(l_busy), .OVF(l_ovf), .D_OUT(l_dout),
    .D_OUT_VALID(l_vld), .CLK_Tx(l_clk)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Records each instance's valid window; index 0 is the call time.
  task automatic capture(input int bound);
    bit m_on, m_done, l_on, l_done;
    m_on = 0; m_done = 0; l_on = 0; l_done = 0;
    m_len = 0; l_len = 0; m_first = -1; l_first = -1;
    for (int i = 0; i < bound && !(m_done && l_done); i++) begin
      if (!m_done) begin
        if (m_vld === 1'b1) begin
          if (!m_on) m_first = i;
          m_on = 1;
          if (m_len < 1024) begin
            m_d[m_len] = m_dout;
            m_c[m_len] = m_clk;
          end
          m_len++;
        end else if (m_on) begin
          m_done = 1;
        end
      end
      if (!l_done) begin
        if (l_vld === 1'b1) begin
          if (!l_on) l_first = i;
          l_on = 1;
          if (l_len < 1024) begin
            l_d[l_len] = l_dout;
            l_c[l_len] = l_clk;
          end
          l_len++;
        end else if (l_on) begin
          l_done = 1;
        end
      end
      tick();
    end
  endtask

  // Mismatches of one captured word against the reference bit/clock shape.
  function automatic int seg_errs(input bit lsb, input int start,
                                  input logic [31:0] w, input int n);
    int   e;
    int   k;
    logic eb, ec, d, c;
    e = 0;
    for (int i = 0; i < 64 * n; i++) begin
      k  = i / (2 * n);
      eb = lsb ? w[k] : w[31-k];
      ec = ((i % (2 * n)) >= n);
      if (start + i > 1023) begin
        e++;
      end else begin
        d = lsb ? l_d[start+i] : m_d[start+i];
        c = lsb ? l_c[start+i] : m_c[start+i];
        if (d !== eb || c !== ec) e++;
      end
    end
    return e;
  endfunction

  task automatic set_div(input logic [31:0] v);
    DIN = v;
    CONFIG_DIV = 1'b1;
    tick();
    CONFIG_DIV = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    int errs;
    DIN = $urandom;
    DATA = $urandom;
    WR_EN = 1'b1;
    CONFIG_DIV = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      got = {m_dout, m_vld, m_clk, m_busy, m_ovf, m_full, m_empty, m_level};
      n_checks++;
      if (got !== 10'b0000001000) begin
        n_fail++;
        $display("FAIL reset_msb_%0d got %b want %b", c, got, 10'b0000001000);
      end
      got = {l_dout, l_vld, l_clk, l_busy, l_ovf, l_full, l_empty, l_level};
      n_checks++;
      if (got !== 10'b0000001000) begin
        n_fail++;
        $display("FAIL reset_lsb_%0d got %b want %b", c, got, 10'b0000001000);
      end
      DIN = $urandom;
      DATA = $urandom;
      tick();
    end
    WR_EN = 1'b0;
    CONFIG_DIV = 1'b0;
    DIN = '0;
    DATA = '0;
    RESET = 1'b0;
    errs = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (m_clk !== 1'b0 || m_busy !== 1'b0) errs++;
      if (l_clk !== 1'b0 || l_busy !== 1'b0) errs++;
    end
    n_checks++;
    if (errs !== 0) begin
      n_fail++;
      $display("FAIL reset_idle got %0d bad cycles want 0", errs);
    end
  endtask

  task automatic test_single_word();
    int rises, badpos, e;
    set_div(32'd2);
    fork
      begin
        WR_EN = 1'b1;
        DATA = 32'h8000_0001;
        tick();
        WR_EN = 1'b0;
      end
      capture(400);
    join
    n_checks++;
    if (m_first !== 2) begin
      n_fail++;
      $display("FAIL single_latency got %0d want 2", m_first);
    end
    n_checks++;
    if (m_len !== 128) begin
      n_fail++;
      $display("FAIL single_len got %0d want 128", m_len);
    end
    e = seg_errs(1'b0, 0, 32'h8000_0001, 2);
    n_checks++;
    if (e !== 0) begin
      n_fail++;
      $display("FAIL single_msb_bits got %0d errs want 0", e);
    end
    e = seg_errs(1'b1, 0, 32'h8000_0001, 2);
    n_checks++;
    if (e !== 0 || l_len !== 128) begin
      n_fail++;
      $display("FAIL single_lsb_bits got %0d errs len %0d want 0/128", e, l_len);
    end
    rises = 0;
    badpos = 0;
    for (int i = 0; i < 128; i++) begin
      if (m_c[i] === 1'b1 && (i == 0 || m_c[i-1] !== 1'b1)) begin
        rises++;
        if (i % 4 != 2) badpos++;
      end
    end
    n_checks++;
    if (rises !== 32 || badpos !== 0) begin
      n_fail++;
      $display("FAIL single_clk_tx got %0d rises %0d misplaced want 32/0",
               rises, badpos);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    set_div(32'd1);
    fork
      begin
        WR_EN = 1'b1;
        DATA = 32'hFFFF_0000;
        tick();
        DATA = 32'h0000_FFFF;
        tick();
        WR_EN = 1'b0;
      end
      capture(400);
    join
    n_checks++;
    if (m_len !== 128) begin
      n_fail++;
      $display("FAIL b2b_len got %0d want 128", m_len);
    end
    e = seg_errs(1'b0, 0, 32'hFFFF_0000, 1)
      + seg_errs(1'b0, 64, 32'h0000_FFFF, 1);
    n_checks++;
    if (e !== 0) begin
      n_fail++;
      $display("FAIL b2b_bits got %0d errs want 0", e);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w [6];
    int e;
    for (int k = 0; k < 6; k++) w[k] = 32'h1357_9BDF ^ (32'h0101_0101 * (k + 1));
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          WR_EN = 1'b1;
          DATA = w[k];
          tick();
          if (k == 4) begin
            n_checks++;
            if (m_full !== 1'b1 || m_level !== 3'd4) begin
              n_fail++;
              $display("FAIL ovf_full got full=%b level=%0d want 1/4",
                       m_full, m_level);
            end
          end
        end
        WR_EN = 1'b0;
        n_checks++;
        if (m_ovf !== 1'b1 || m_level !== 3'd4) begin
          n_fail++;
          $display("FAIL ovf_flag got ovf=%b level=%0d want 1/4",
                   m_ovf, m_level);
        end
      end
      capture(700);
    join
    n_checks++;
    if (m_len !== 320) begin
      n_fail++;
      $display("FAIL ovf_len got %0d want 320", m_len);
    end
    e = 0;
    for (int k = 0; k < 5; k++) e += seg_errs(1'b0, 64 * k, w[k], 1);
    n_checks++;
    if (e !== 0) begin
      n_fail++;
      $display("FAIL ovf_order got %0d errs want 0", e);
    end
    tick();
    n_checks++;
    if (m_ovf !== 1'b1 || l_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky got %b%b want 11", m_ovf, l_ovf);
    end
  endtask

  task automatic test_div_change();
    int e;
    fork
      begin
        WR_EN = 1'b1;
        DATA = 32'hC3C3_5A5A;
        tick();
        DATA = 32'h9696_F00F;
        tick();
        WR_EN = 1'b0;
        repeat (30) tick();
        set_div(32'd3);
      end
      capture(500);
    join
    n_checks++;
    if (m_len !== 256) begin
      n_fail++;
      $display("FAIL divchg_len got %0d want 256", m_len);
    end
    e = seg_errs(1'b0, 0, 32'hC3C3_5A5A, 1);
    n_checks++;
    if (e !== 0) begin
      n_fail++;
      $display("FAIL divchg_word_a got %0d errs want 0", e);
    end
    e = seg_errs(1'b0, 64, 32'h9696_F00F, 3);
    n_checks++;
    if (e !== 0) begin
      n_fail++;
      $display("FAIL divchg_word_b got %0d errs want 0", e);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [9:0] got;
    int e;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    WR_EN = 1'b1;
    DATA = 32'h0000_0003;
    tick();
    WR_EN = 1'b0;
    tick();
    repeat (10) tick();
    n_checks++;
    if (l_vld !== 1'b1 || m_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_active got %b%b want 11", l_vld, m_vld);
    end
    RESET = 1'b1;
    #1;
    got = {l_dout, l_vld, l_clk, l_busy, l_ovf, l_full, l_empty, l_level};
    n_checks++;
    if (got !== 10'b0000001000) begin
      n_fail++;
      $display("FAIL midrst_lsb_outs got %b want %b", got, 10'b0000001000);
    end
    got = {m_dout, m_vld, m_clk, m_busy, m_ovf, m_full, m_empty, m_level};
    n_checks++;
    if (got !== 10'b0000001000) begin
      n_fail++;
      $display("FAIL midrst_msb_outs got %b want %b", got, 10'b0000001000);
    end
    tick();
    RESET = 1'b0;
    repeat (3) tick();
    fork
      begin
        WR_EN = 1'b1;
        DATA = 32'h0000_0003;
        tick();
        WR_EN = 1'b0;
      end
      capture(300);
    join
    e = seg_errs(1'b1, 0, 32'h0000_0003, 1);
    n_checks++;
    if (e !== 0 || l_len !== 64) begin
      n_fail++;
      $display("FAIL midrst_lsb_word got %0d errs len %0d want 0/64", e, l_len);
    end
    e = seg_errs(1'b0, 0, 32'h0000_0003, 1);
    n_checks++;
    if (e !== 0 || m_len !== 64) begin
      n_fail++;
      $display("FAIL midrst_msb_word got %0d errs len %0d want 0/64", e, m_len);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overflow();
    test_div_change();
    test_reset_mid_word();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_tx_unit.md
Name: serial_tx_unit

Overview:
Parametrised serial transmit engine for the calculator output path. It generalises the fixed-width, single-word, divided-clock serial transfer into a block with configurable word width, configurable bit order and an input FIFO. The FIFO allows results to be sent back-to-back with no gap between words. It sits between the result/memory datapath, which pushes words, and the off-chip serial pins D_OUT, D_OUT_VALID and CLK_Tx.

Parameters:
DATA_W, 32, width of each transmitted word in bits (>=2)
DIV_W, 32, width of the clock-divisor register and of DIN
FIFO_DEPTH, 4, number of buffered words; power of two, >=2
MSB_FIRST, 1, 1 sends bit DATA_W-1 first; 0 sends bit 0 first

Ports:
CLK  in  1  system clock; all state changes on its rising edge
RESET  in  1  asynchronous, active-high reset
CONFIG_DIV  in  1  when high, DIN is loaded into the divisor register
DIN  in  DIV_W  divisor value
WR_EN  in  1  push DATA into the FIFO
DATA  in  DATA_W  word to transmit
FULL  out  1  FIFO holds FIFO_DEPTH words
EMPTY  out  1  FIFO holds 0 words
LEVEL  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
BUSY  out  1  high in SHIFT or when the FIFO is non-empty
OVF  out  1  sticky flag: a write was dropped
D_OUT  out  1  serial data
D_OUT_VALID  out  1  D_OUT carries a valid bit
CLK_Tx  out  1  divided transmit clock

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - FIFO emptied; LEVEL=0, EMPTY=1, FULL=0.
  - Divisor register = 1; OVF=0; FSM in IDLE.
  - D_OUT=0, D_OUT_VALID=0, CLK_Tx=0, BUSY=0.
  - A word in flight is abandoned; it is never resumed.
- Divisor:
  - CONFIG_DIV is sampled every cycle, in any state. The divisor register updates on the next edge.
  - A divisor value of 0 is treated as 1.
  - The effective divisor N is latched at each word load. A change during a word takes effect from the next word.
- Bit timing:
  - Each bit lasts 2N CLK cycles.
  - CLK_Tx is low for the first N cycles of the bit and high for the last N, so the receiver samples on the CLK_Tx rising edge.
  - CLK_Tx is held low outside SHIFT.
- FIFO:
  - A write is accepted when WR_EN=1 and FULL=0, both as registered at that edge.
  - A write while FULL is dropped, even if a pop occurs in the same cycle, and sets OVF.
  - Simultaneous write and pop when not full: LEVEL is unchanged and both operations occur.
  - Words leave in first-in, first-out order.
- FSM, IDLE:
  - If EMPTY=0: pop the head word into the shift register, load the bit counter with DATA_W, latch N, go to SHIFT.
  - Otherwise stay in IDLE.
- FSM, SHIFT:
  - D_OUT_VALID=1 throughout.
  - D_OUT = current bit: MSB or LSB first per MSB_FIRST.
  - After 2N cycles the engine advances to the next bit.
  - After the last bit of a word:
    - If the FIFO is non-empty, pop and load the next word in the same edge; the first bit of the new word follows immediately with no idle cycle and the new N applies.
    - Otherwise return to IDLE; D_OUT_VALID=0 and D_OUT=0 from that edge.
- Latency: with WR_EN sampled at edge t into an idle, empty block, D_OUT_VALID rises at edge t+1 and the first bit is held for 2N cycles.
- Duration: one word occupies exactly DATA_W*2N cycles of D_OUT_VALID=1.
- BUSY is combinational: (state==SHIFT) OR (EMPTY=0).

Test Plan:
1. Reset: assert RESET with random inputs -> all outputs at their reset values; deassert, then 20 idle cycles -> CLK_Tx stays 0 and BUSY stays 0.
2. DIN=2 with CONFIG_DIV pulse, then write 32'h8000_0001 (MSB_FIRST=1) -> D_OUT_VALID high for exactly 128 cycles; D_OUT=1 for cycles 0-3, 0 for cycles 4-123, 1 for cycles 124-127; 32 CLK_Tx rising edges, each at cycle offset 2 of its bit.
3. Back-to-back: divisor 1, write 32'hFFFF_0000 then 32'h0000_FFFF on consecutive cycles -> D_OUT_VALID high for a continuous 128 cycles; D_OUT shows 16 ones, 32 zeros, 16 ones in 2-cycle bits.
4. Overflow: divisor 1, FIFO_DEPTH=4, six writes on consecutive cycles -> sixth write dropped, FULL=1 at that edge, OVF=1 until reset; words 1-5 transmitted in order, word 6 never appears.
5. Divisor change mid-word: set DIN=3 while word A (divisor 1) is halfway sent, with word B queued -> A completes using 2-cycle bits; B uses 6-cycle bits; no gap between A and B.
6. Reset mid-word plus LSB order: with MSB_FIRST=0, start 32'h0000_0003 and assert RESET at cycle 10 -> all outputs 0 immediately; after release, write 32'h0000_0003 -> first two bits 1, then 30 zeros.
